adc_frame_buffer: RTL

- Sits directly downstream of the ADC SPI reader, which delivers a 16-bit raw word plus a data-valid strobe per conversion.
- Collects consecutive samples into N-sample frames using a ping-pong double buffer, two banks of N words.
- Hands each complete frame to the FFT stage through a ready/done ownership handshake with random-access reads.
- One bank fills while the FFT consumes the other.

---
 rtl/adc_frame_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/adc_frame_buffer.sv
// Ping-pong frame buffer between the ADC SPI reader and the FFT stage.
// Optional build macro ADC_TWOS_COMP_EN: store samples as sign-extended two's complement.
module adc_frame_buffer #(
  parameter int N_SAMPLES = 64,
  parameter int DATA_W    = 16,
  parameter int ADC_BITS  = 12,
  parameter int ADC_SHIFT = 0,
  localparam int AW = $clog2(N_SAMPLES)
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [15:0]       DATA_IN,
  input  logic              DV,
  input  logic [AW-1:0]     RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              FRAME_READY,
  input  logic              FRAME_DONE,
  output logic              OVERRUN,
  output logic [AW:0]       FILL_LEVEL
);

  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(N_SAMPLES);
  localparam logic [AW-1:0] LAST_IDX   = AW'(N_SAMPLES - 1);

  typedef enum logic {FILL, FULL_WAIT} state_t;

  state_t            state_q;
  logic              dv_prev_q;
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [AW-1:0]     wr_ptr_q;
  logic              ready_q;
  logic              handoff_q;
  logic              overrun_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [2*N_SAMPLES];

  logic [ADC_BITS-1:0] field;
  logic [DATA_W-1:0]   sample_d;
  logic                accept;
  logic                frame_release;
  logic                last_write;
  logic                wr_en;

  assign field = ADC_BITS'(DATA_IN >> ADC_SHIFT);

  always_comb begin
    sample_d = '0;
`ifdef ADC_TWOS_COMP_EN
    // Inverting the offset-binary MSB gives the sign; replicate it upward.
    for (int i = 0; i < DATA_W; i++) begin
      sample_d[i] = ~field[ADC_BITS-1];
    end
    sample_d[ADC_BITS-2:0] = field[ADC_BITS-2:0];
`else
    sample_d[ADC_BITS-1:0] = field;
`endif
  end

  assign accept        = DV & ~dv_prev_q;
  assign frame_release = FRAME_DONE & ready_q;
  assign last_write    = (wr_ptr_q == LAST_IDX);
  assign wr_en         = accept & (state_q == FILL);

  always_ff @(posedge CLOCK) begin
    if (wr_en) begin
      mem[{wr_bank_q, wr_ptr_q}] <= sample_d;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rd_data_q <= '0;
    end else if (ready_q) begin
      rd_data_q <= mem[{rd_bank_q, RD_ADDR}];
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= FILL;
      dv_prev_q <= 1'b1;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      ready_q   <= 1'b0;
      handoff_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dv_prev_q <= DV;
      handoff_q <= 1'b0;
      // handoff_q delays a new frame by one cycle after a release so the consumer sees a low gap.
      if (handoff_q) begin
        ready_q <= 1'b1;
      end
      if (frame_release) begin
        ready_q <= 1'b0;
      end
      case (state_q)
        FILL: begin
          if (accept) begin
            if (last_write) begin
              if (ready_q && !FRAME_DONE) begin
                state_q <= FULL_WAIT;
              end else begin
                rd_bank_q <= wr_bank_q;
                wr_bank_q <= ~wr_bank_q;
                wr_ptr_q  <= '0;
                if (frame_release) begin
                  handoff_q <= 1'b1;
                end else begin
                  ready_q <= 1'b1;
                end
              end
            end else begin
              wr_ptr_q <= wr_ptr_q + AW'(1);
            end
          end
        end
        FULL_WAIT: begin
          if (accept) begin
            overrun_q <= 1'b1;
          end
          if (frame_release) begin
            rd_bank_q <= wr_bank_q;
            wr_bank_q <= ~wr_bank_q;
            wr_ptr_q  <= '0;
            handoff_q <= 1'b1;
            state_q   <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign RD_DATA     = rd_data_q;
  assign FRAME_READY = ready_q;
  assign OVERRUN     = overrun_q;
  assign FILL_LEVEL  = (state_q == FULL_WAIT) ? FULL_LEVEL : {1'b0, wr_ptr_q};

endmodule
